// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding, limits
// and a small ring-index helper used by the round-robin picker.
package fifo_arb_pkg;

   // Upper bound on the number of write requesters the arbiter supports.
   localparam int MAX_NUM_REQ = 8;

   // IDLE picks the next owner; BURST streams beats from that owner.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   // Index that lies 'step' places after 'idx' on a ring of 'n' entries.
   function automatic int ring_next(input int idx, input int step, input int n);
      return (idx + step) % n;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first requester found scanning the
// ring from last_winner+1 wins. Outputs are all zero when nobody requests.
module rr_priority_picker
   import fifo_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_winner_i,
   output logic [N-1:0]  gnt_oh_o,
   output logic [IW-1:0] gnt_idx_o
);

   logic          found;
   logic [IW-1:0] cand;

   // Walk the ring once, starting just after the previous winner.
   always_comb begin
      found     = 1'b0;
      cand      = '0;
      gnt_idx_o = '0;
      gnt_oh_o  = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IW'(ring_next(int'(last_winner_i), k, N));
         if (!found && req_i[cand]) begin
            found     = 1'b1;
            gnt_idx_o = cand;
         end
      end
      if (found) begin
         gnt_oh_o[gnt_idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that lets several requesters share one FIFO write port.
// A winner is chosen in IDLE and then owns the port for up to MAX_BURST beats,
// until its packet ends or until it withdraws its request.
//
// Handshake: a requester offers one beat by holding req[i] high with its
// data and req_last; the beat is consumed in the cycle gnt[i]=1 (which is
// also the cycle w_en=1). gnt/w_en are combinational and drop whenever
// fifo_full is high, so the requester must keep its beat stable until granted.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int  NUM_REQ    = 4,
   parameter int  DATA_WIDTH = 8,
   parameter int  MAX_BURST  = 4,
   localparam int OW         = $clog2(NUM_REQ),
   localparam int CW         = $clog2(MAX_BURST + 1)
) (
   input  logic                          wclk,
   input  logic                          wrst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic                          fifo_full,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          w_en,
   output logic [DATA_WIDTH-1:0]         data_in,
   output logic [OW-1:0]                 owner,
   output logic                          busy,
   output arb_state_e                    state_dbg
);

   localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST);
   localparam logic [OW-1:0] LAST_RST   = OW'(NUM_REQ - 1);

   arb_state_e        state_q, state_d;
   logic [OW-1:0]     owner_q, owner_d;
   logic [OW-1:0]     last_q, last_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     cnt_inc;
   logic [NUM_REQ-1:0] pick_oh;
   logic [OW-1:0]     pick_idx;
   logic              owner_req;
   logic              owner_last;

   rr_priority_picker #(
      .N  (NUM_REQ),
      .IW (OW)
   ) u_picker (
      .req_i         (req),
      .last_winner_i (last_q),
      .gnt_oh_o      (pick_oh),
      .gnt_idx_o     (pick_idx)
   );

   assign owner_req  = req[owner_q];
   assign owner_last = req_last[owner_q];
   assign cnt_inc    = cnt_q + 1'b1;

   // State, owner, beat counter and round-robin pointer; reset makes
   // requester 0 the first in line.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         cnt_q   <= '0;
         last_q  <= LAST_RST;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   // Next-state logic and FIFO write enable; a full FIFO simply stalls the burst.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      w_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|pick_oh) begin
               state_d = ST_BURST;
               owner_d = pick_idx;
               cnt_d   = '0;
            end
         end
         ST_BURST: begin
            w_en = owner_req & ~fifo_full;
            if (w_en) begin
               cnt_d = cnt_inc;
               if (owner_last || (cnt_inc == BURST_LAST)) begin
                  state_d = ST_IDLE;
                  last_d  = owner_q;
               end
            end else if (!owner_req) begin
               state_d = ST_IDLE;
               last_d  = owner_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // One-hot beat acknowledge, only ever at the current owner.
   always_comb begin
      gnt          = '0;
      gnt[owner_q] = w_en;
   end

   assign data_in   = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
   assign owner     = owner_q;
   assign busy      = (state_q == ST_BURST);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a behavioural grant model checked
// every cycle, plus literal expected owner sequences for each scenario.
module tb_fifo_write_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            wclk = 1'b0;
  logic            wrst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic            fifo_full = 1'b0;
  logic [N-1:0]    gnt;
  logic            w_en;
  logic [DW-1:0]   data_in;
  logic [1:0]      owner;
  logic            busy;
  arb_state_e      state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [1:0] act_q[$];
  logic [1:0] exp_q[$];

  fifo_write_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req       (req),
    .req_data  (req_data),
    .req_last  (req_last),
    .fifo_full (fifo_full),
    .gnt       (gnt),
    .w_en      (w_en),
    .data_in   (data_in),
    .owner     (owner),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock
  always #5 wclk = ~wclk;

  // ---------------- behavioural model ----------------
  // A session is either open (m_busy) with an owner and a beat count, or
  // closed. Opening picks the nearest requester after the last winner.
  logic       m_busy;
  logic [1:0] m_owner;
  logic [1:0] m_last;
  int         m_beats;

  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] p;
    p = last;
    for (int k = N; k >= 1; k--) begin
      if (r[2'(int'(last) + k)]) p = 2'(int'(last) + k);
    end
    return p;
  endfunction

  logic          exp_wen;
  logic [N-1:0]  exp_gnt;
  logic [DW-1:0] exp_data;
  assign exp_wen  = m_busy && req[m_owner] && !fifo_full;
  assign exp_gnt  = exp_wen ? (4'b0001 << m_owner) : 4'b0000;
  assign exp_data = req_data[int'(m_owner)*DW +: DW];

  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      m_busy  <= 1'b0;
      m_owner <= 2'd0;
      m_beats <= 0;
      m_last  <= 2'(N - 1);
    end else if (!m_busy) begin
      if (|req) begin
        m_busy  <= 1'b1;
        m_owner <= pick(req, m_last);
        m_beats <= 0;
      end
    end else if (exp_wen) begin
      m_beats <= m_beats + 1;
      if (req_last[m_owner] || (m_beats + 1 == MB)) begin
        m_busy <= 1'b0;
        m_last <= m_owner;
      end
    end else if (!req[m_owner]) begin
      m_busy <= 1'b0;
      m_last <= m_owner;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: outputs against the model, away from the rising edge
  always @(negedge wclk) begin
    chk("w_en", 32'(w_en), 32'(exp_wen));
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("state_dbg", 32'(state_dbg), 32'(m_busy ? ST_BURST : ST_IDLE));
    chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    if (m_busy) chk("owner", 32'(owner), 32'(m_owner));
    if (exp_wen) chk("data_in", 32'(data_in), 32'(exp_data));
    if (w_en) act_q.push_back(owner);
  end

  task automatic check_log(input string name);
    chk({name, "_len"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      chk(name, 32'(act_q[i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic push_exp(input logic [1:0] o, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(o);
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge wclk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(i*64 + cyc%64);
  endtask

  task automatic do_reset();
    step();
    wrst_n = 1'b0;
    req = '0; req_last = '0; fifo_full = 1'b0;
    step();
    step();
    @(negedge wclk);
    wrst_n = 1'b1;
    act_q.delete();
  endtask

  logic [3:0] pats[8] = '{4'b1010, 4'b0110, 4'b1111, 4'b0001,
                          4'b1000, 4'b0101, 4'b1110, 4'b0011};

  initial begin
    // reset with everyone requesting
    req = 4'b1111;
    step();
    step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_wen", 32'(w_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // round robin: 0,1,2,3,0 each for MAX_BURST beats
    @(negedge wclk);
    wrst_n = 1'b1;
    act_q.delete();
    repeat (25) step();
    req = '0;
    step();
    step();
    chk("rst_first_owner", 32'(act_q.size() > 0 ? act_q[0] : 2'd3), 32'd0);
    push_exp(2'd0, 4); push_exp(2'd1, 4); push_exp(2'd2, 4);
    push_exp(2'd3, 4); push_exp(2'd0, 4);
    check_log("round_robin");

    // packet end after 2 beats, then requester 1
    do_reset();
    req = 4'b0011;
    step();
    step();
    req_last = 4'b0001;
    step();
    chk("pkt_idle", 32'(busy), 32'd0);
    req_last = '0;
    req = 4'b0010;
    repeat (5) step();
    req = '0;
    step();
    step();
    push_exp(2'd0, 2); push_exp(2'd1, 4);
    check_log("packet_end");

    // full stall mid-burst for 5 cycles
    do_reset();
    req = 4'b0001;
    step();
    step();
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_wen", 32'(w_en), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_owner", 32'(owner), 32'd0);
    end
    fifo_full = 1'b0;
    repeat (3) step();
    req = '0;
    step();
    step();
    push_exp(2'd0, 4);
    check_log("full_stall");

    // owner drops request after one beat
    do_reset();
    req = 4'b0011;
    step();
    step();
    req = 4'b0010;
    step();
    chk("drop_idle", 32'(busy), 32'd0);
    repeat (5) step();
    req = '0;
    step();
    step();
    push_exp(2'd0, 1); push_exp(2'd1, 4);
    check_log("drop_req");

    // asynchronous reset between edges in the middle of a burst
    do_reset();
    req = 4'b1111;
    step();
    step();
    chk("pre_arst_wen", 32'(w_en), 32'd1);
    #2;
    wrst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_wen", 32'(w_en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge wclk);
    wrst_n = 1'b1;
    act_q.delete();
    repeat (3) step();
    push_exp(2'd0, 2);
    check_log("arst_restart");

    // mixed requests, packet ends and full pulses, checked by the model
    do_reset();
    for (int i = 0; i < 48; i++) begin
      req = pats[i%8];
      req_last = (i % 5 == 2) ? 4'b1111 : 4'b0000;
      fifo_full = (i % 7 == 3) || (i % 7 == 4);
      step();
    end
    req = '0;
    req_last = '0;
    fifo_full = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
